// File: rtl/noc_pkg.sv
// Shared definitions for the NoC input VC buffer: sizes, flit type encoding
// and the field layout of the request bundle handed to the input router.
package noc_pkg;

    localparam int FLIT_W = 34;
    localparam int NUM_VC = 3;
    localparam int VC_W   = 2;

    localparam int VALID_BIT = 0;
    localparam int VC_LSB    = 1;
    localparam int FLIT_LSB  = 3;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC circular FIFO. Exposes the head and the entry behind it so the
// arbiter can present the next flit in the same cycle the head is popped.
module noc_vc_fifo #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [FLIT_W-1:0] i_data,
    output logic [FLIT_W-1:0] o_head,
    output logic [FLIT_W-1:0] o_head_nxt,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_multi
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_rptr_nxt;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign w_rptr_nxt = r_rptr + PTR_W'(1);
    assign o_head     = r_mem[r_rptr];
    assign o_head_nxt = r_mem[w_rptr_nxt];
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_multi    = (r_count > CNT_W'(1));

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Per-VC input buffering with a round-robin arbiter that presents one flit at
// a time to the input router and holds it until acknowledged.
module noc_input_vc_buffer
    import noc_pkg::*;
#(
    parameter int NUM_VC    = noc_pkg::NUM_VC,
    parameter int VC_W      = noc_pkg::VC_W,
    parameter int FLIT_W    = noc_pkg::FLIT_W,
    parameter int BUF_DEPTH = 4,
    localparam int REQ_W    = 1 + VC_W + FLIT_W
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              fin_valid_i,
    input  logic [VC_W-1:0]   fin_vc_i,
    input  logic [FLIT_W-1:0] fin_flit_i,
    output logic [NUM_VC-1:0] fin_ready_o,
    output logic [REQ_W-1:0]  flit_req_o,
    input  logic              flit_ack_i,
    output logic [NUM_VC-1:0] buf_empty_o,
    output logic              err_o
);

    arb_state_t        r_state;
    logic [VC_W-1:0]   r_sel_vc;
    logic [VC_W-1:0]   r_rr_ptr;
    logic [REQ_W-1:0]  r_req;
    logic              r_err;

    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_multi;
    logic [NUM_VC-1:0] w_push;
    logic [NUM_VC-1:0] w_pop;
    logic [FLIT_W-1:0] w_head     [NUM_VC];
    logic [FLIT_W-1:0] w_head_nxt [NUM_VC];

    logic              w_vc_ok;
    logic              w_tgt_full;
    logic              w_push_ok;
    logic              w_bad_push;
    logic              w_acked;
    logic [NUM_VC-1:0] w_avail;
    logic [VC_W-1:0]   w_start;
    logic              w_found;
    logic [VC_W-1:0]   w_pick;
    logic [FLIT_W-1:0] w_pick_flit;

    function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] vc);
        return (vc == VC_W'(NUM_VC - 1)) ? '0 : vc + VC_W'(1);
    endfunction

    function automatic logic [REQ_W-1:0] pack_req(input logic [FLIT_W-1:0] flit,
                                                  input logic [VC_W-1:0]   vc);
        logic [REQ_W-1:0] p;
        p                      = '0;
        p[VALID_BIT]           = 1'b1;
        p[VC_LSB +: VC_W]      = vc;
        p[FLIT_LSB +: FLIT_W]  = flit;
        return p;
    endfunction

    // Ready reflects start-of-cycle occupancy only, so a same-cycle pop never
    // opens room in a full FIFO.
    assign w_vc_ok    = ({1'b0, fin_vc_i} < (VC_W + 1)'(NUM_VC));
    assign w_tgt_full = w_vc_ok ? w_full[fin_vc_i] : 1'b1;
    assign w_push_ok  = fin_valid_i && w_vc_ok && !w_tgt_full;
    assign w_bad_push = fin_valid_i && !(w_vc_ok && !w_tgt_full);
    assign w_acked    = (r_state == ARB_HOLD) && flit_ack_i;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_push[v] = w_push_ok && (fin_vc_i == VC_W'(v));
        assign w_pop[v]  = w_acked && (r_sel_vc == VC_W'(v));

        noc_vc_fifo #(
            .FLIT_W (FLIT_W),
            .DEPTH  (BUF_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .arst       (arst),
            .i_push     (w_push[v]),
            .i_pop      (w_pop[v]),
            .i_data     (fin_flit_i),
            .o_head     (w_head[v]),
            .o_head_nxt (w_head_nxt[v]),
            .o_full     (w_full[v]),
            .o_empty    (w_empty[v]),
            .o_multi    (w_multi[v])
        );
    end

    // Arbitration sees the post-pop view of the acked VC; same-cycle pushes
    // only become eligible once they are stored.
    always_comb begin
        int idx;
        w_avail     = ~w_empty;
        w_start     = r_rr_ptr;
        w_found     = 1'b0;
        w_pick      = '0;
        w_pick_flit = '0;
        idx         = 0;
        if (w_acked) begin
            w_avail[r_sel_vc] = w_multi[r_sel_vc];
            w_start           = next_vc(r_sel_vc);
        end
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (int'(w_start) + i) % NUM_VC;
            if (!w_found && w_avail[idx]) begin
                w_found = 1'b1;
                w_pick  = VC_W'(idx);
            end
        end
        w_pick_flit = (w_acked && (w_pick == r_sel_vc)) ? w_head_nxt[w_pick]
                                                         : w_head[w_pick];
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state  <= ARB_IDLE;
            r_sel_vc <= '0;
            r_rr_ptr <= '0;
            r_req    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_bad_push) r_err <= 1'b1;
            if (w_acked)    r_rr_ptr <= next_vc(r_sel_vc);
            if ((r_state == ARB_IDLE) || w_acked) begin
                if (w_found) begin
                    r_state  <= ARB_HOLD;
                    r_sel_vc <= w_pick;
                    r_req    <= pack_req(w_pick_flit, w_pick);
                end else begin
                    r_state  <= ARB_IDLE;
                    r_req    <= '0;
                end
            end
        end
    end

    assign fin_ready_o = ~w_full;
    assign buf_empty_o = w_empty;
    assign flit_req_o  = r_req;
    assign err_o       = r_err;

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Directed bench for noc_input_vc_buffer with a queue-based reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_noc_input_vc_buffer;

    localparam int NV    = 3;
    localparam int VW    = 2;
    localparam int FW    = 34;
    localparam int RW    = 1 + VW + FW;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          fin_valid = 1'b0;
    logic [VW-1:0] fin_vc = '0;
    logic [FW-1:0] fin_flit = '0;
    logic          ack = 1'b0;
    logic [NV-1:0] fin_ready;
    logic [RW-1:0] flit_req;
    logic [NV-1:0] buf_empty;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    noc_input_vc_buffer dut (
        .clk         (clk),
        .arst        (arst),
        .fin_valid_i (fin_valid),
        .fin_vc_i    (fin_vc),
        .fin_flit_i  (fin_flit),
        .fin_ready_o (fin_ready),
        .flit_req_o  (flit_req),
        .flit_ack_i  (ack),
        .buf_empty_o (buf_empty),
        .err_o       (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per VC, a held-grant flag and a rr pointer.
    logic [FW-1:0] mq [NV][$];
    bit            m_hold = 1'b0;
    int            m_sel = 0;
    int            m_rr = 0;
    bit            m_err = 1'b0;
    logic [RW-1:0] m_req = '0;

    always @(posedge clk or negedge arst) begin : model
        bit legal;
        int v;
        if (!arst) begin
            for (int i = 0; i < NV; i++) mq[i].delete();
            m_hold = 1'b0;
            m_sel  = 0;
            m_rr   = 0;
            m_err  = 1'b0;
            m_req  = '0;
        end else begin
            legal = 1'b0;
            if (fin_valid && (int'(fin_vc) < NV)) begin
                if (mq[fin_vc].size() < DEPTH) legal = 1'b1;
            end
            if (fin_valid && !legal) m_err = 1'b1;
            if (m_hold && ack) begin
                void'(mq[m_sel].pop_front());
                m_rr   = (m_sel + 1) % NV;
                m_hold = 1'b0;
            end
            if (!m_hold) begin
                m_req = '0;
                for (int i = 0; i < NV; i++) begin
                    v = (m_rr + i) % NV;
                    if (!m_hold && mq[v].size() > 0) begin
                        m_hold = 1'b1;
                        m_sel  = v;
                        m_req  = {mq[v][0], 2'(v), 1'b1};
                    end
                end
            end
            if (legal) mq[fin_vc].push_back(fin_flit);
        end
    end

    always @(negedge clk) begin : compare
        logic [NV-1:0] er;
        logic [NV-1:0] ee;
        for (int i = 0; i < NV; i++) begin
            er[i] = (mq[i].size() < DEPTH);
            ee[i] = (mq[i].size() == 0);
        end
        chk("model_req",   64'(flit_req),  64'(m_req));
        chk("model_ready", 64'(fin_ready), 64'(er));
        chk("model_empty", 64'(buf_empty), 64'(ee));
        chk("model_err",   64'(err),       64'(m_err));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [VW-1:0] vc, input logic [FW-1:0] flit);
        fin_valid = 1'b1;
        fin_vc    = vc;
        fin_flit  = flit;
        cyc();
        fin_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        arst = 1'b0;
        #1;
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_req", 64'(flit_req), 64'd0);
        cyc();
        arst = 1'b1;
        cyc();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int            ev [6];
        logic [FW-1:0] ef [6];
        logic [FW-1:0] ff [5];

        #2 arst = 1'b0;
        cyc();
        cyc();
        chk("reset_req",   64'(flit_req),  64'd0);
        chk("reset_ready", 64'(fin_ready), 64'h7);
        chk("reset_empty", 64'(buf_empty), 64'h7);
        chk("reset_err",   64'(err),       64'd0);
        arst = 1'b1;
        cyc();

        // Single flit on VC1, type HEAD
        push(2'd1, 34'h0_0000_00A5);
        chk("t1_not_yet", 64'(flit_req), 64'd0);
        chk("t1_empty",   64'(buf_empty), 64'h5);
        cyc();
        chk("t1_req", 64'(flit_req), 64'h52B);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_hold", 64'(flit_req), 64'h52B);
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t1_clear", 64'(flit_req), 64'd0);
        chk("t1_drained", 64'(buf_empty), 64'h7);

        // Round robin over two flits per VC, ack held high
        push(2'd0, 34'h100);
        push(2'd0, 34'h101);
        push(2'd1, 34'h110);
        push(2'd1, 34'h111);
        push(2'd2, 34'h120);
        push(2'd2, 34'h121);
        cyc();
        ev = '{0, 1, 2, 0, 1, 2};
        ef = '{34'h100, 34'h110, 34'h120, 34'h101, 34'h111, 34'h121};
        ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_seq", 64'(flit_req), 64'({ef[i], 2'(ev[i]), 1'b1}));
            cyc();
        end
        ack = 1'b0;
        chk("rr_done", 64'(flit_req), 64'd0);

        // Full VC2, fifth push dropped
        ff = '{{2'b00, 32'd1}, {2'b01, 32'd2}, {2'b01, 32'd3}, {2'b10, 32'd4}, {2'b11, 32'd5}};
        for (int i = 0; i < 4; i++) push(2'd2, ff[i]);
        chk("full_ready", 64'(fin_ready), 64'h3);
        chk("full_noerr", 64'(err), 64'd0);
        push(2'd2, ff[4]);
        chk("full_err",   64'(err), 64'd1);
        chk("full_ready2", 64'(fin_ready), 64'h3);
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_order", 64'(flit_req), 64'({ff[i], 2'd2, 1'b1}));
            cyc();
        end
        ack = 1'b0;
        chk("full_done", 64'(flit_req), 64'd0);
        chk("full_empty", 64'(buf_empty), 64'h7);
        reset_pulse();

        // Out-of-range VC id
        push(2'd3, 34'h7);
        chk("badvc_err",   64'(err), 64'd1);
        chk("badvc_empty", 64'(buf_empty), 64'h7);
        cyc();
        chk("badvc_req",   64'(flit_req), 64'd0);
        reset_pulse();

        // Simultaneous push and pop on VC0 across pointer wrap
        push(2'd0, 34'h200);
        push(2'd0, 34'h201);
        cyc();
        chk("sp_first", 64'(flit_req), 64'({34'h200, 2'd0, 1'b1}));
        for (int i = 0; i < 8; i++) begin
            fin_valid = 1'b1;
            fin_vc    = 2'd0;
            fin_flit  = 34'(32'h202 + i);
            ack       = 1'b1;
            cyc();
            chk("sp_req",   64'(flit_req), 64'({34'(32'h201 + i), 2'd0, 1'b1}));
            chk("sp_ready", 64'(fin_ready), 64'h7);
        end
        fin_valid = 1'b0;
        cyc();
        chk("sp_tail", 64'(flit_req), 64'({34'h209, 2'd0, 1'b1}));
        cyc();
        ack = 1'b0;
        chk("sp_done", 64'(flit_req), 64'd0);
        chk("sp_empty", 64'(buf_empty), 64'h7);

        // Reset while holding with three flits buffered
        push(2'd1, {2'b00, 32'h300});
        push(2'd1, {2'b01, 32'h301});
        push(2'd1, {2'b10, 32'h302});
        cyc();
        chk("mid_hold", 64'(flit_req), 64'({2'b00, 32'h300, 2'd1, 1'b1}));
        arst = 1'b0;
        #1;
        chk("mid_async_req", 64'(flit_req), 64'd0);
        chk("mid_empty",     64'(buf_empty), 64'h7);
        chk("mid_ready",     64'(fin_ready), 64'h7);
        cyc();
        cyc();
        arst = 1'b1;
        cyc();
        cyc();
        chk("post_empty", 64'(buf_empty), 64'h7);
        chk("post_req",   64'(flit_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
